// File: rtl/dac_i2s_tx.sv
// dac_i2s_tx: playback FIFO feeding an I2S DAC serialiser.
// The codec owns i2s_bclk and i2s_daclrc; both are synchronised into clk and
// data is shifted out MSB first, one BCLK after each LRC transition.
// Optional feature: define DAC_TX_UNDERRUN_CNT_EN to add the 16-bit
// saturating underrun_cnt output.
//
// Write handshake: a word on wr_data is accepted on every rising clk edge
// where wr_en is high and full is low; a write presented while full is
// dropped (even if a pop happens in that same cycle). full, almost_full and
// empty are decoded from registered pointers, so they move the cycle after
// the write or pop that changes the level.
module dac_i2s_tx #(
  parameter int FIFO_DEPTH = 256,
  parameter int AFULL_LVL  = 128,
  parameter int SAMPLE_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  output logic        full,
  output logic        almost_full,
  output logic        empty,
  input  logic        i2s_bclk,
  input  logic        i2s_daclrc,
  output logic        i2s_dacdat,
`ifdef DAC_TX_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
`endif
  output logic        underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_W + 1);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic          wr_ok;
  logic          pop;
  logic [31:0]   pop_word;

  logic          bclk_s1, bclk_s2, bclk_d;
  logic          lrc_s1, lrc_s2;
  logic          lrc_prev;
  logic          bclk_fall;
  logic          chan_start;
  logic          left_start;
  logic          right_start;
  logic          underrun_next;
  logic          seen_left;

  // Only the right half needs holding; the left half is loaded straight
  // from the popped word at the left-channel start.
  logic [15:0]   hold_right;
  logic [15:0]   shift;
  logic [CW-1:0] bit_cnt;

  // Extra pointer bit separates full (MSBs differ) from empty (equal).
  assign level       = wr_ptr - rd_ptr;
  assign full        = (level == (AW+1)'(FIFO_DEPTH));
  assign almost_full = (level >= (AW+1)'(AFULL_LVL));
  assign empty       = (level == '0);

  assign bclk_fall     = bclk_d & ~bclk_s2;
  assign chan_start    = bclk_fall && (lrc_s2 != lrc_prev);
  assign left_start    = chan_start && !lrc_s2;
  assign right_start   = chan_start && lrc_s2 && seen_left;
  assign wr_ok         = wr_en && !full;
  assign pop           = left_start && !empty;
  assign underrun_next = left_start && empty;
  assign pop_word      = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

  // Two-flop synchronisers, plus one more bclk stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_d  <= 1'b0;
      lrc_s1  <= 1'b0;
      lrc_s2  <= 1'b0;
    end else begin
      bclk_s1 <= i2s_bclk;
      bclk_s2 <= bclk_s1;
      bclk_d  <= bclk_s2;
      lrc_s1  <= i2s_daclrc;
      lrc_s2  <= lrc_s1;
    end
  end

  // FIFO storage; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // FIFO pointers and the underrun pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      underrun <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      underrun <= underrun_next;
    end
  end

  // Serialiser: at each BCLK fall, emit the pending bit, then either load
  // a new channel or shift. A channel start still emits the previous LSB,
  // so channels exactly SAMPLE_W BCLKs long are not truncated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lrc_prev   <= 1'b0;
      seen_left  <= 1'b0;
      hold_right <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      i2s_dacdat <= 1'b0;
    end else if (bclk_fall) begin
      lrc_prev   <= lrc_s2;
      i2s_dacdat <= (bit_cnt != '0) ? shift[15] : 1'b0;
      if (left_start) begin
        seen_left  <= 1'b1;
        hold_right <= pop_word[15:0];
        shift      <= pop_word[31:16];
        bit_cnt    <= CW'(SAMPLE_W);
      end else if (right_start) begin
        shift      <= hold_right;
        bit_cnt    <= CW'(SAMPLE_W);
      end else if (bit_cnt != '0) begin
        shift      <= {shift[14:0], 1'b0};
        bit_cnt    <= bit_cnt - 1'b1;
      end
    end
  end

`ifdef DAC_TX_UNDERRUN_CNT_EN
  // Saturating count of underrun events since reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (underrun_next && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Testbench for dac_i2s_tx: directed scenarios, one task each.
module tb_dac_i2s_tx;

  logic        clk;
  logic        reset;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        full;
  logic        almost_full;
  logic        empty;
  logic        i2s_bclk;
  logic        i2s_daclrc;
  logic        i2s_dacdat;
  logic        underrun;
`ifdef DAC_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int ur_count = 0;
  logic [31:0] exp_q[$];

  dac_i2s_tx dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .i2s_bclk    (i2s_bclk),
    .i2s_daclrc  (i2s_daclrc),
    .i2s_dacdat  (i2s_dacdat),
`ifdef DAC_TX_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .underrun    (underrun)
  );

  // Clock and underrun pulse counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (underrun === 1'b1) ur_count++;
  end

  // Driver tasks
  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    i2s_bclk = 1'b1;
    i2s_daclrc = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_data = w;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One BCLK period: fall (with new LRC), high phase, sample just before next fall.
  task automatic bclk_bit(input logic lrc, input int half, output logic b);
    i2s_bclk = 1'b0;
    i2s_daclrc = lrc;
    repeat (half) @(negedge clk);
    i2s_bclk = 1'b1;
    repeat (half) @(negedge clk);
    b = i2s_dacdat;
  endtask

  // 16 BCLKs left then 16 right; fb[31-i] is the bit driven at fall i.
  task automatic run_frame(input int half, output logic [31:0] fb);
    logic b;
    for (int i = 0; i < 32; i++) begin
      bclk_bit(i >= 16, half, b);
      fb[31-i] = b;
    end
  endtask

  task automatic preamble(input int half);
    logic b;
    repeat (2) bclk_bit(1'b1, half, b);
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
    n_checks++; if (almost_full !== 1'b0) $display("FAIL reset_afull: got %b want 0", almost_full); else n_pass++;
    n_checks++; if (i2s_dacdat !== 1'b0) $display("FAIL reset_dacdat: got %b want 0", i2s_dacdat); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
`ifdef DAC_TX_UNDERRUN_CNT_EN
    n_checks++; if (underrun_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", underrun_cnt); else n_pass++;
`endif
    wr_en = 1'b0;
    do_reset();
  endtask

  task automatic test_frame_output();
    logic [31:0] fb1, fb2;
    do_reset();
    write_word(32'hA5A5_0F0F);
    preamble(8);
    run_frame(8, fb1);
    run_frame(8, fb2);
    n_checks++; if (fb1[31] !== 1'b0) $display("FAIL frame_pre_bit: got %b want 0", fb1[31]); else n_pass++;
    n_checks++; if (fb1[30:15] !== 16'hA5A5) $display("FAIL frame_left: got %h want a5a5", fb1[30:15]); else n_pass++;
    n_checks++; if ({fb1[14:0], fb2[31]} !== 16'h0F0F) $display("FAIL frame_right: got %h want 0f0f", {fb1[14:0], fb2[31]}); else n_pass++;
    n_checks++; if (fb2[30:0] !== 31'h0) $display("FAIL frame_empty_second: got %h want 0", fb2[30:0]); else n_pass++;
  endtask

  task automatic test_fill_levels();
    logic [31:0] fb;
    logic [15:0] k16;
    do_reset();
    for (int k = 1; k <= 257; k++) begin
      k16 = 16'(k - 1);
      wr_data = {k16 ^ 16'h5A00, ~k16};
      wr_en = 1'b1;
      @(negedge clk);
      if (k == 127) begin
        n_checks++; if (almost_full !== 1'b0) $display("FAIL fill_afull_127: got %b want 0", almost_full); else n_pass++;
      end
      if (k == 128) begin
        n_checks++; if (almost_full !== 1'b1) $display("FAIL fill_afull_128: got %b want 1", almost_full); else n_pass++;
      end
      if (k == 255) begin
        n_checks++; if (full !== 1'b0) $display("FAIL fill_full_255: got %b want 0", full); else n_pass++;
      end
      if (k == 256) begin
        n_checks++; if (full !== 1'b1) $display("FAIL fill_full_256: got %b want 1", full); else n_pass++;
      end
    end
    wr_en = 1'b0;
    n_checks++; if (full !== 1'b1) $display("FAIL fill_full_257: got %b want 1", full); else n_pass++;
    preamble(4);
    run_frame(4, fb);
    n_checks++; if (fb[30:15] !== 16'h5A00) $display("FAIL fill_first_pop: got %h want 5a00", fb[30:15]); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL fill_full_after_pop: got %b want 0", full); else n_pass++;
  endtask

  task automatic test_underrun();
    logic [31:0] fb;
    logic [31:0] acc;
    int base;
    do_reset();
    preamble(4);
    base = ur_count;
    acc = '0;
    repeat (3) begin
      run_frame(4, fb);
      acc = acc | fb;
    end
    n_checks++; if (acc !== 32'h0) $display("FAIL underrun_data: got %h want 0", acc); else n_pass++;
    n_checks++; if (ur_count - base !== 3) $display("FAIL underrun_pulses: got %0d want 3", ur_count - base); else n_pass++;
`ifdef DAC_TX_UNDERRUN_CNT_EN
    n_checks++; if (underrun_cnt !== 16'd3) $display("FAIL underrun_cnt: got %0d want 3", underrun_cnt); else n_pass++;
`endif
  endtask

  task automatic test_write_during_pop();
    do_reset();
    preamble(4);
    i2s_bclk = 1'b0;
    i2s_daclrc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_data = 32'h1357_9BDF;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++; if (underrun !== 1'b1) $display("FAIL wdp_underrun: got %b want 1", underrun); else n_pass++;
    n_checks++; if (empty !== 1'b0) $display("FAIL wdp_empty: got %b want 0", empty); else n_pass++;
`ifdef DAC_TX_UNDERRUN_CNT_EN
    n_checks++; if (underrun_cnt !== 16'd1) $display("FAIL wdp_cnt: got %0d want 1", underrun_cnt); else n_pass++;
`endif
    @(negedge clk);
    n_checks++; if (underrun !== 1'b0) $display("FAIL wdp_pulse_len: got %b want 0", underrun); else n_pass++;
    n_checks++; if ({empty, full} !== 2'b00) $display("FAIL wdp_level: got %b want 00", {empty, full}); else n_pass++;
    i2s_bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic b;
    logic acc;
    logic [31:0] fb;
    do_reset();
    write_word(32'hA5A5_0F0F);
    write_word(32'h1234_5678);
    preamble(4);
    bclk_bit(1'b0, 4, b);
    bclk_bit(1'b0, 4, b);
    n_checks++; if (b !== 1'b1) $display("FAIL rmf_msb: got %b want 1", b); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (i2s_dacdat !== 1'b0) $display("FAIL rmf_dacdat: got %b want 0", i2s_dacdat); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL rmf_empty: got %b want 1", empty); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    write_word(32'h8001_C003);
    acc = 1'b0;
    repeat (14) begin
      bclk_bit(1'b0, 4, b);
      acc = acc | b;
    end
    repeat (16) begin
      bclk_bit(1'b1, 4, b);
      acc = acc | b;
    end
    n_checks++; if (acc !== 1'b0) $display("FAIL rmf_quiet: got %b want 0", acc); else n_pass++;
    n_checks++; if (empty !== 1'b0) $display("FAIL rmf_no_pop: got %b want 0", empty); else n_pass++;
    run_frame(4, fb);
    n_checks++; if (fb[31:15] !== 17'h08001) $display("FAIL rmf_left: got %h want 08001", fb[31:15]); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] fb, prev_fb;
    logic [31:0] cur, prev_word;
    logic [31:0] w;
    logic [15:0] i16;
    logic b;
    int base;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      i16 = 16'(i);
      w = {i16 ^ 16'hC35A, i16 * 16'd3 + 16'h1234};
      exp_q.push_back(w);
      write_word(w);
    end
    preamble(4);
    base = ur_count;
    prev_fb = '0;
    prev_word = '0;
    for (int n = 0; n < 300; n++) begin
      i16 = 16'(n + 2);
      w = {i16 ^ 16'hC35A, i16 * 16'd3 + 16'h1234};
      exp_q.push_back(w);
      write_word(w);
      cur = exp_q.pop_front();
      run_frame(4, fb);
      if (n > 0) begin
        n_checks++;
        if ({prev_fb[30:0], fb[31]} !== prev_word)
          $display("FAIL wrap_word_%0d: got %h want %h", n - 1, {prev_fb[30:0], fb[31]}, prev_word);
        else n_pass++;
      end
      prev_fb = fb;
      prev_word = cur;
    end
    bclk_bit(1'b0, 4, b);
    n_checks++;
    if ({prev_fb[30:0], b} !== prev_word)
      $display("FAIL wrap_word_last: got %h want %h", {prev_fb[30:0], b}, prev_word);
    else n_pass++;
    n_checks++; if (ur_count - base !== 0) $display("FAIL wrap_underruns: got %0d want 0", ur_count - base); else n_pass++;
  endtask

  // Sequence and final report
  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    i2s_bclk = 1'b1;
    i2s_daclrc = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame_output();
    test_fill_levels();
    test_underrun();
    test_write_during_pop();
    test_reset_mid_frame();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_i2s_tx.md
DAC_I2S_TX -- requirements
Module: dac_i2s_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 256: playback FIFO depth in 32-bit words; power of two.
REQ-002 SHALL have parameter AFULL_LVL, default 128: fill level at or above which almost_full asserts.
REQ-003 SHALL have parameter SAMPLE_W, default 16: bits per channel; word = {left[31:16], right[15:0]}.
REQ-004 SHALL have port clk  in  1: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port wr_data  in  32: DSP playback word.
REQ-007 SHALL have port wr_en  in  1: one word written per clk cycle while high.
REQ-008 SHALL have port full  out  1: FIFO holds FIFO_DEPTH words.
REQ-009 SHALL have port almost_full  out  1: fill level >= AFULL_LVL.
REQ-010 SHALL have port empty  out  1: fill level = 0.
REQ-011 SHALL have port i2s_bclk  in  1: codec bit clock, asynchronous to clk.
REQ-012 SHALL have port i2s_daclrc  in  1: codec DAC word clock; low = left, high = right.
REQ-013 SHALL have port i2s_dacdat  out  1: serial DAC data, MSB first.
REQ-014 SHALL have port underrun  out  1: one-clk pulse when a frame starts with FIFO empty.

Function
REQ-015 SHALL pass i2s_bclk and i2s_daclrc through two-flop synchronisers before any use.
REQ-016 SHALL detect a BCLK falling edge as synchronised bclk 1 then 0; clk frequency >= 8x BCLK is required.
REQ-017 SHALL sample synchronised LRC at each BCLK falling edge and flag a channel start when it differs from the value at the previous falling edge.
REQ-018 SHALL, on a left-channel start (LRC 1->0), pop one FIFO word into a frame hold register, or load 0 and pulse underrun if empty.
REQ-019 SHALL, on a channel start, load the shift register with hold[31:16] (left) or hold[15:0] (right), with the left half taken from the word just popped.
REQ-020 SHALL drive the channel MSB on i2s_dacdat starting at the BCLK falling edge after the channel start (I2S one-bit delay), then one bit per falling edge.
REQ-021 SHALL drive 0 after SAMPLE_W bits until the next channel start.
REQ-022 SHALL update i2s_dacdat within 4 clk cycles of the synchronised BCLK falling edge.
REQ-023 SHALL ignore wr_en while full, including when a pop occurs in the same cycle; fill level unchanged.
REQ-024 SHALL, on wr_en with an empty FIFO and a pop in the same cycle, pulse underrun and accept the write; fill level ends at 1.
REQ-025 SHALL update full/almost_full/empty the cycle after the write or pop that changes the level.
REQ-026 SHALL wrap read and write pointers modulo FIFO_DEPTH, using an extra pointer bit to distinguish full from empty.
REQ-027 SHALL ignore a right-channel start seen before any left start since reset, keeping dacdat 0.

Reset
REQ-028 SHALL, while reset is high, force: FIFO empty (empty=1, full=0, almost_full=0), i2s_dacdat=0, underrun=0, hold and shift registers 0, and synchronisers 0.
REQ-029 SHALL, after a reset mid-frame, output 0 until the first left-channel start following deassertion.

Configuration
REQ-030 SHALL compile in, with macro DAC_TX_UNDERRUN_CNT_EN defined, an output port underrun_cnt (out, 16 bits) that increments per underrun pulse, saturates at 0xFFFF, and resets to 0.
REQ-031 SHALL omit, without DAC_TX_UNDERRUN_CNT_EN, the underrun_cnt port and its counter; all other behaviour is identical.

Verification
REQ-032 SHALL cover: write 0xA5A5_0F0F, then run frames at BCLK = clk/16 -> left bits 1010010110100101, right bits 0000111100001111, each MSB one BCLK after the LRC edge.
REQ-033 SHALL cover: 256 writes with no frames -> almost_full at the 128th write, full after the 256th; 257th write dropped; next pop reads word 0.
REQ-034 SHALL cover: frames with FIFO empty -> dacdat constantly 0, one underrun pulse per left start; with the macro defined, underrun_cnt = 3 after 3 frames.
REQ-035 SHALL cover: wr_en in the same cycle as a pop on an empty FIFO -> underrun pulses, empty=0 next cycle, level 1.
REQ-036 SHALL cover: reset asserted mid-left-channel -> dacdat=0 immediately, empty=1, no output until the next LRC 1->0.
REQ-037 SHALL cover: 300 continuous frames with the writer keeping up -> pointers wrap, output words match input order, zero underruns.
